// File: rtl/cpu_pkg.sv
// Shared CPU widths and index/word types for the issue path.
// Pure definitions; no logic, latency or backpressure of its own.
package cpu_pkg;
  localparam int DATA_WIDTH    = 32;
  localparam int NUM_REGISTERS = 32;
  localparam int PAYLOAD_WIDTH = 64;
  localparam int RW            = $clog2(NUM_REGISTERS);

  typedef logic [RW-1:0]         reg_idx_t;
  typedef logic [DATA_WIDTH-1:0] word_t;
endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Per-register pending-write bits with set/clear/flush and three busy queries.
// Queries are combinational; updates take effect on the next posedge. No backpressure.
module operand_fetch_scoreboard #(
  parameter int NUM_REGISTERS = cpu_pkg::NUM_REGISTERS,
  localparam int RW = $clog2(NUM_REGISTERS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          set_en,
  input  logic [RW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [RW-1:0] clr_idx,
  input  logic [RW-1:0] query_a,
  input  logic [RW-1:0] query_b,
  input  logic [RW-1:0] query_c,
  output logic          busy_a,
  output logic          busy_b,
  output logic          busy_c
);
  logic [NUM_REGISTERS-1:0] busy;

  // Register 0 never holds a pending write, so its query is forced low.
  assign busy_a = (query_a != '0) && busy[query_a];
  assign busy_b = (query_b != '0) && busy[query_b];
  assign busy_c = (query_c != '0) && busy[query_c];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy <= '0;
    end else begin
      if (clr_en && clr_idx != '0) busy[clr_idx] <= 1'b0;
      // Later assignment wins: a new writer issued this cycle stays pending.
      if (set_en && set_idx != '0) busy[set_idx] <= 1'b1;
    end
  end
endmodule

// File: rtl/operand_fetch.sv
// Issue stage: reads/forwards operands, stalls on RAW/WAW, registers them for execute.
// Latency 1 cycle accept-to-out_valid; full throughput; stalls upstream while out is held.
module operand_fetch #(
  parameter int DATA_WIDTH    = cpu_pkg::DATA_WIDTH,
  parameter int NUM_REGISTERS = cpu_pkg::NUM_REGISTERS,
  parameter int PAYLOAD_WIDTH = cpu_pkg::PAYLOAD_WIDTH,
  localparam int RW = $clog2(NUM_REGISTERS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [RW-1:0]            in_rs1,
  input  logic [RW-1:0]            in_rs2,
  input  logic [RW-1:0]            in_rd,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  output logic [RW-1:0]            rf_read_register_1,
  output logic [RW-1:0]            rf_read_register_2,
  input  logic [DATA_WIDTH-1:0]    rf_result_1,
  input  logic [DATA_WIDTH-1:0]    rf_result_2,
  input  logic                     wb_valid,
  input  logic [RW-1:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_rs1_data,
  output logic [DATA_WIDTH-1:0]    out_rs2_data,
  output logic [RW-1:0]            out_rd,
  output logic [PAYLOAD_WIDTH-1:0] out_payload
);
  logic busy_rs1, busy_rs2, busy_rd;
  logic wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
  logic stall, accept;
  logic [DATA_WIDTH-1:0] op1, op2;

  assign rf_read_register_1 = in_rs1;
  assign rf_read_register_2 = in_rs2;

  assign wb_hit_rs1 = wb_valid && (wb_rd == in_rs1);
  assign wb_hit_rs2 = wb_valid && (wb_rd == in_rs2);
  assign wb_hit_rd  = wb_valid && (wb_rd == in_rd);

  // The RF write lands a cycle after wb_valid, so the same-cycle value is bypassed.
  always_comb begin
    op1 = rf_result_1;
    op2 = rf_result_2;
    if (in_rs1 == '0)    op1 = '0;
    else if (wb_hit_rs1) op1 = wb_data;
    if (in_rs2 == '0)    op2 = '0;
    else if (wb_hit_rs2) op2 = wb_data;
  end

  assign stall = (busy_rs1 && !wb_hit_rs1)
              || (busy_rs2 && !wb_hit_rs2)
              || (in_rd != '0 && busy_rd && !wb_hit_rd);

  assign in_ready = !rst && !flush && !stall && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  operand_fetch_scoreboard #(.NUM_REGISTERS(NUM_REGISTERS)) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .set_en  (accept),
    .set_idx (in_rd),
    .clr_en  (wb_valid),
    .clr_idx (wb_rd),
    .query_a (in_rs1),
    .query_b (in_rs2),
    .query_c (in_rd),
    .busy_a  (busy_rs1),
    .busy_b  (busy_rs2),
    .busy_c  (busy_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_rd       <= '0;
      out_payload  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_rs1_data <= op1;
      out_rs2_data <= op2;
      out_rd       <= in_rd;
      out_payload  <= in_payload;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: reset, forwarding, stalls, backpressure, zero reg, flush.
module tb_operand_fetch;
  import cpu_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid, in_ready;
  reg_idx_t                 in_rs1, in_rs2, in_rd;
  logic [PAYLOAD_WIDTH-1:0] in_payload;
  reg_idx_t                 rf_read_register_1, rf_read_register_2;
  word_t                    rf_result_1, rf_result_2;
  logic                     wb_valid;
  reg_idx_t                 wb_rd;
  word_t                    wb_data;
  logic                     flush;
  logic                     out_valid, out_ready;
  word_t                    out_rs1_data, out_rs2_data;
  reg_idx_t                 out_rd;
  logic [PAYLOAD_WIDTH-1:0] out_payload;

  word_t rf_mem [NUM_REGISTERS];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rf_result_1 = rf_mem[rf_read_register_1];
  assign rf_result_2 = rf_mem[rf_read_register_2];

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_payload(in_payload),
    .rf_read_register_1(rf_read_register_1), .rf_read_register_2(rf_read_register_2),
    .rf_result_1(rf_result_1), .rf_result_2(rf_result_2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_payload(out_payload)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input int rs1, input int rs2, input int rd,
                          input logic [63:0] pl);
    in_valid   = v;
    in_rs1     = reg_idx_t'(rs1);
    in_rs2     = reg_idx_t'(rs2);
    in_rd      = reg_idx_t'(rd);
    in_payload = pl;
  endtask

  task automatic drive_wb(input logic v, input int rd, input logic [31:0] d);
    wb_valid = v;
    wb_rd    = reg_idx_t'(rd);
    wb_data  = d;
  endtask

  initial begin
    for (int i = 0; i < NUM_REGISTERS; i++) rf_mem[i] = 32'hA000_0000 + i;
    rf_mem[0] = 32'hDEAD_BEEF;
    rf_mem[1] = 32'h11; rf_mem[2] = 32'h22; rf_mem[3] = 32'h7; rf_mem[4] = 32'h9;
    rf_mem[7] = 32'h77;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive_in(1'b0, 0, 0, 0, 64'h0);
    drive_wb(1'b0, 0, 32'h0);

    // 1. reset, then simple issue
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_out_payload", out_payload, 0);
    check("rst_out_data", out_rs1_data, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    drive_in(1'b1, 3, 4, 5, 64'h0000_00A5_0000_0001);
    #1 check("t1_in_ready", in_ready, 1);
    check("t1_rf_addr1", rf_read_register_1, 3);
    check("t1_no_valid_yet", out_valid, 0);
    step();
    drive_in(1'b0, 0, 0, 0, 64'h0);
    check("t1_out_valid", out_valid, 1);
    check("t1_rs1", out_rs1_data, 7);
    check("t1_rs2", out_rs2_data, 9);
    check("t1_rd", out_rd, 5);
    check("t1_payload", out_payload, 64'h0000_00A5_0000_0001);

    // 2. RAW stall on r5 until writeback forwards
    drive_in(1'b1, 5, 0, 0, 64'h2);
    #1 check("t2_stall_a", in_ready, 0);
    step();
    check("t2_drained", out_valid, 0);
    check("t2_stall_b", in_ready, 0);
    drive_wb(1'b1, 5, 32'h1234);
    #1 check("t2_wb_unstall", in_ready, 1);
    step();
    drive_wb(1'b0, 0, 32'h0);
    drive_in(1'b0, 0, 0, 0, 64'h0);
    check("t2_out_valid", out_valid, 1);
    check("t2_fwd_rs1", out_rs1_data, 32'h1234);
    check("t2_rs2_zero", out_rs2_data, 0);

    // 3. backpressure hold, then back-to-back
    out_ready = 1'b0;
    drive_in(1'b1, 1, 2, 8, 64'h3);
    for (int c = 0; c < 4; c++) begin
      #1;
      check("t3_hold_in_ready", in_ready, 0);
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_rs1", out_rs1_data, 32'h1234);
      check("t3_hold_payload", out_payload, 64'h2);
      step();
    end
    out_ready = 1'b1;
    #1 check("t3_release", in_ready, 1);
    step();
    check("t3_a_valid", out_valid, 1);
    check("t3_a_rs1", out_rs1_data, 32'h11);
    check("t3_a_rs2", out_rs2_data, 32'h22);
    check("t3_a_rd", out_rd, 8);
    drive_in(1'b1, 3, 4, 9, 64'h4);
    #1 check("t3_b2b_ready", in_ready, 1);
    step();
    drive_in(1'b0, 0, 0, 0, 64'h0);
    check("t3_b_valid", out_valid, 1);
    check("t3_b_rd", out_rd, 9);
    check("t3_b_payload", out_payload, 64'h4);
    step();
    check("t3_drain", out_valid, 0);

    // 4. zero register: never forwarded, never busy
    drive_in(1'b1, 0, 0, 0, 64'h5);
    drive_wb(1'b1, 0, 32'hFFFF);
    #1 check("t4_ready", in_ready, 1);
    step();
    drive_wb(1'b0, 0, 32'h0);
    check("t4_rs1", out_rs1_data, 0);
    check("t4_rs2", out_rs2_data, 0);
    check("t4_rd", out_rd, 0);
    #1 check("t4_no_busy_r0", in_ready, 1);
    step();
    drive_in(1'b0, 0, 0, 0, 64'h0);

    // 5. same-cycle set/clear on r6 keeps it busy
    drive_in(1'b1, 0, 0, 6, 64'h6);
    step();
    drive_wb(1'b1, 6, 32'h66);
    #1 check("t5_waw_cleared_by_wb", in_ready, 1);
    step();
    drive_wb(1'b0, 0, 32'h0);
    check("t5_out_rd", out_rd, 6);
    drive_in(1'b1, 6, 0, 0, 64'h7);
    #1 check("t5_r6_still_busy", in_ready, 0);

    // 6. flush clears busy bits and the output register
    drive_in(1'b1, 0, 0, 2, 64'h8);
    step();
    drive_in(1'b1, 0, 0, 7, 64'h9);
    step();
    drive_in(1'b0, 0, 0, 0, 64'h0);
    out_ready = 1'b0;
    check("t6_pre_valid", out_valid, 1);
    drive_in(1'b1, 2, 7, 9, 64'hA);
    #1 check("t6_pre_stall", in_ready, 0);
    flush = 1'b1;
    #1 check("t6_flush_blocks", in_ready, 0);
    step();
    flush = 1'b0;
    check("t6_flushed_valid", out_valid, 0);
    #1 check("t6_no_stall", in_ready, 1);
    step();
    drive_in(1'b0, 0, 0, 0, 64'h0);
    check("t6_out_valid", out_valid, 1);
    check("t6_rs1", out_rs1_data, 32'h22);
    check("t6_rs2", out_rs2_data, 32'h77);
    check("t6_rd", out_rd, 9);

    // mid-operation reset drops the held instruction
    rst = 1'b1;
    step();
    check("rst2_valid", out_valid, 0);
    check("rst2_rd", out_rd, 0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
